// File: rtl/frame_buf_ctrl_pkg.sv
// Shared strobe levels, bank-state and FSM encodings for the ping-pong frame buffer controller.
package frame_buf_ctrl_pkg;

    localparam logic ASSERT   = 1'b0;
    localparam logic DEASSERT = 1'b1;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_READING = 2'd2
    } bank_state_e;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_e;

endpackage

// File: rtl/frame_buf_ctrl_bank_tracker.sv
// Holds the EMPTY/FULL/READING state of both banks and remembers which bank was filled last.
module bank_tracker
    import frame_buf_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        full_en,
    input  logic        full_bank,
    input  logic        take_en,
    input  logic        take_bank,
    input  logic        free_en,
    input  logic        free_bank,
    output bank_state_e state_0,
    output bank_state_e state_1,
    output logic        oldest_vld,
    output logic        oldest_bank
);

    bank_state_e st [2];
    logic        last_filled;

    // Writer only completes an EMPTY bank and the reader only takes/frees other banks,
    // so the three updates never target the same bank in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st[0]       <= BANK_EMPTY;
            st[1]       <= BANK_EMPTY;
            last_filled <= 1'b1;
        end else begin
            if (full_en) begin
                st[full_bank] <= BANK_FULL;
                last_filled   <= full_bank;
            end
            if (take_en) st[take_bank] <= BANK_READING;
            if (free_en) st[free_bank] <= BANK_EMPTY;
        end
    end

    always_comb begin
        oldest_vld = (st[0] == BANK_FULL) || (st[1] == BANK_FULL);
        if ((st[0] == BANK_FULL) && (st[1] == BANK_FULL)) oldest_bank = ~last_filled;
        else                                                oldest_bank = (st[1] == BANK_FULL);
    end

    assign state_0 = st[0];
    assign state_1 = st[1];

endmodule

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer controller: fills one bank of an external data_mem while the other drains.
// wr_en_in/rd_en_in are active-low per-cycle requests; a write is taken only while wr_rdy is high
// (else dropped with wr_ovf), a read only when a frame is available (else refused with rd_unf).
module frame_buf_ctrl
    import frame_buf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en_in,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH:0]   mem_wr_addr,
    output logic [ADDR_WIDTH:0]   mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  wr_rdy,
    output logic                  rd_vld,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic                  wr_ovf,
    output logic                  rd_unf,
    output wr_state_e             wr_state,
    output rd_state_e             rd_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;

    logic                  wb, rb;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
    bank_state_e           state_0, state_1, other_wr_st, other_rd_st;
    logic                  oldest_vld, oldest_bank;
    logic                  wr_fire, wr_last, rd_fire, rd_last, rd_take_idle, take_en, take_bank;
    logic                  rd_last_q;

    always_comb begin
        wr_fire      = (wr_state == W_FILL) && (wr_en_in == ASSERT);
        wr_last      = wr_fire && (wr_idx == LAST_IDX);
        rd_fire      = (rd_state == R_DRAIN) && (rd_en_in == ASSERT);
        rd_last      = rd_fire && (rd_idx == LAST_IDX);
        other_wr_st  = wb ? state_0 : state_1;
        other_rd_st  = rb ? state_0 : state_1;
        rd_take_idle = (rd_state == R_IDLE) && (rd_en_in == ASSERT) && oldest_vld;
        take_en      = rd_take_idle || (rd_last && (other_rd_st == BANK_FULL));
        take_bank    = rd_take_idle ? oldest_bank : ~rb;
    end

    bank_tracker u_bank_tracker (
        .clk         (clk),
        .reset       (reset),
        .full_en     (wr_last),
        .full_bank   (wb),
        .take_en     (take_en),
        .take_bank   (take_bank),
        .free_en     (rd_last),
        .free_bank   (rb),
        .state_0     (state_0),
        .state_1     (state_1),
        .oldest_vld  (oldest_vld),
        .oldest_bank (oldest_bank)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state      <= W_FILL;
            wb            <= 1'b0;
            wr_idx        <= '0;
            mem_wr_en     <= DEASSERT;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            wr_frame_done <= 1'b0;
            wr_ovf        <= 1'b0;
        end else begin
            mem_wr_en     <= DEASSERT;
            wr_frame_done <= 1'b0;
            wr_ovf        <= 1'b0;
            case (wr_state)
                W_FILL: if (wr_fire) begin
                    mem_wr_en   <= ASSERT;
                    mem_wr_addr <= {wb, wr_idx};
                    mem_wr_data <= data_in;
                    wr_idx      <= wr_idx + IDX_ONE;
                    if (wr_last) begin
                        wr_frame_done <= 1'b1;
                        wb            <= ~wb;
                        // The other bank being released on this very edge counts as EMPTY.
                        if (!((other_wr_st == BANK_EMPTY) || (rd_last && (rb == ~wb))))
                            wr_state <= W_STALL;
                    end
                end
                W_STALL: begin
                    if (wr_en_in == ASSERT) wr_ovf <= 1'b1;
                    if (state_0 == BANK_EMPTY) begin
                        wr_state <= W_FILL;
                        wb       <= 1'b0;
                    end else if (state_1 == BANK_EMPTY) begin
                        wr_state <= W_FILL;
                        wb       <= 1'b1;
                    end
                end
                default: wr_state <= W_FILL;
            endcase
        end
    end

    assign wr_rdy = (wr_state == W_FILL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state      <= R_IDLE;
            rb            <= 1'b0;
            rd_idx        <= '0;
            mem_rd_en     <= DEASSERT;
            mem_rd_addr   <= '0;
            rd_vld        <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_frame_done <= 1'b0;
            rd_unf        <= 1'b0;
        end else begin
            mem_rd_en     <= DEASSERT;
            rd_unf        <= 1'b0;
            rd_vld        <= (mem_rd_en == ASSERT);
            rd_last_q     <= rd_last;
            rd_frame_done <= rd_last_q;
            case (rd_state)
                R_IDLE: if (rd_en_in == ASSERT) begin
                    // A request that finds a FULL bank claims it and issues its first pixel.
                    if (oldest_vld) begin
                        rd_state    <= R_DRAIN;
                        rb          <= oldest_bank;
                        mem_rd_en   <= ASSERT;
                        mem_rd_addr <= {oldest_bank, {ADDR_WIDTH{1'b0}}};
                        rd_idx      <= IDX_ONE;
                    end else begin
                        rd_unf <= 1'b1;
                    end
                end
                R_DRAIN: if (rd_fire) begin
                    mem_rd_en   <= ASSERT;
                    mem_rd_addr <= {rb, rd_idx};
                    rd_idx      <= rd_idx + IDX_ONE;
                    if (rd_last) begin
                        if (other_rd_st == BANK_FULL) rb       <= ~rb;
                        else                          rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_buf_ctrl.md
FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 24: pixel width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3: per-bank pixel address width; frame length FRAME_LEN = 1 << ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = in reset).
REQ-005 wr_en_in  input  1  active-low; writer presents one pixel this cycle.
REQ-006 data_in  input  DATA_WIDTH  pixel accompanying wr_en_in.
REQ-007 rd_en_in  input  1  active-low; reader requests one pixel this cycle.
REQ-008 mem_wr_en  output  1  active-low write strobe to data_mem.
REQ-009 mem_rd_en  output  1  active-low read strobe to data_mem.
REQ-010 mem_wr_addr  output  ADDR_WIDTH+1  {bank, pixel index} write address.
REQ-011 mem_rd_addr  output  ADDR_WIDTH+1  {bank, pixel index} read address.
REQ-012 mem_wr_data  output  DATA_WIDTH  registered copy of data_in.
REQ-013 wr_rdy  output  1  active-high; a bank is available for writing.
REQ-014 rd_vld  output  1  active-high; data_mem rd_data is valid this cycle.
REQ-015 wr_frame_done, rd_frame_done  output  1 each  one-cycle pulses at end of a written or read frame.
REQ-016 wr_ovf, rd_unf  output  1 each  one-cycle pulses: write dropped, read refused.

Function
REQ-017 The block SHALL run two banks (0, 1) as ping-pong; each bank state is EMPTY, FULL or READING.
REQ-018 Writer FSM SHALL have states W_FILL (writing bank wb) and W_STALL (no EMPTY bank).
REQ-019 In W_FILL, each cycle with wr_en_in = 0 SHALL register one write: mem_wr_en = 0 the next cycle at {wb, wr_idx}, after which wr_idx increments.
REQ-020 When the write at wr_idx = FRAME_LEN-1 is accepted, bank wb SHALL become FULL and wr_frame_done SHALL pulse; wr_idx wraps to 0; the writer moves to the other bank if EMPTY, else to W_STALL.
REQ-021 In W_STALL, wr_rdy SHALL be 0; wr_en_in = 0 SHALL drop the pixel (no memory write) and pulse wr_ovf; the writer returns to W_FILL the cycle after a bank becomes EMPTY.
REQ-022 Reader FSM SHALL have states R_IDLE and R_DRAIN; leaving R_IDLE requires a FULL bank, which becomes READING as rb.
REQ-023 In R_DRAIN, each cycle with rd_en_in = 0 SHALL issue mem_rd_en = 0 at {rb, rd_idx} the next cycle; rd_vld SHALL assert one cycle after that strobe (data_mem read latency 1).
REQ-024 After the read at rd_idx = FRAME_LEN-1 is issued, bank rb SHALL become EMPTY and rd_frame_done SHALL pulse coincident with the last rd_vld; the reader enters R_DRAIN on the other bank if it is FULL, else R_IDLE.
REQ-025 rd_en_in = 0 in R_IDLE SHALL be refused (no memory read) and pulse rd_unf.
REQ-026 Bank selection after reset SHALL be the lowest-numbered bank; with both banks FULL, the reader SHALL take the bank filled first.
REQ-027 A bank becoming EMPTY and a write completing in the same cycle SHALL both take effect; the writer SHALL NOT stall.
REQ-028 The writer SHALL never write a bank that is FULL or READING; the reader SHALL never read a bank that is EMPTY.
REQ-029 Index arithmetic SHALL be unsigned ADDR_WIDTH-bit and wrap modulo FRAME_LEN.

Reset
REQ-030 While reset = 0: both banks EMPTY, writer W_FILL on bank 0, reader R_IDLE, indices 0, mem_wr_en = mem_rd_en = 1, addresses and mem_wr_data 0, wr_rdy = 1, all other outputs 0.
REQ-031 Reset asserted mid-frame SHALL discard partial frames; no strobe SHALL be issued on the first cycle after release.

Structure
REQ-032 ASSERT/DEASSERT values, bank-state and FSM encodings SHALL live in the shared defines package used by frame_buf.
REQ-033 The block SHALL contain no storage array; it drives one data_mem instance (ADDR_WIDTH+1) in its parent. A sub-module bank_tracker SHALL hold both bank states and the fill order.

Verification (DATA_WIDTH=24, ADDR_WIDTH=3)
REQ-034 Write 8 pixels 0x000001..0x000008 back-to-back, then read 8 -> wr_frame_done at write 8; reads return 0x000001..0x000008 in order from bank 0; rd_frame_done with 8th rd_vld.
REQ-035 Write 16 with no reads, then a 17th -> banks 0 and 1 FULL, wr_rdy = 0, 17th pulses wr_ovf, memory untouched.
REQ-036 Read at reset release -> rd_unf pulses, mem_rd_en stays 1.
REQ-037 Both banks FULL; drain bank 0 while writing continuously -> writer resumes on bank 0 the cycle after its last read issues; the next read frame comes from bank 1.
REQ-038 Pull reset low after 5 writes, release, write 8, read 8 -> data of the second sequence only, from bank 0.
